// File: rtl/shift194_ctrl.sv
// Command sequencer for a DM74LS194-style 4-bit universal shift register.
// Accepts clear/load/shift/rotate commands and drives the register's control pins.
module shift194_ctrl #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             CR,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [3:0]       cmd_data,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic             cmd_fill,
    input  logic [3:0]       q,
    output logic             reg_clr_n,
    output logic             S1,
    output logic             S0,
    output logic             SR,
    output logic             SL,
    output logic [3:0]       par,
    output logic             busy,
    output logic             done
);

    // Handshake: a command transfers on a rising edge where cmd_valid and
    // cmd_ready are both 1; cmd_ready is high only in IDLE, so cmd_* are
    // ignored while a command is running or completing.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_SHR  = 3'd2;
    localparam logic [2:0] OP_SHL  = 3'd3;
    localparam logic [2:0] OP_ROR  = 3'd4;
    localparam logic [2:0] OP_ROL  = 3'd5;
    localparam logic [2:0] OP_CLR  = 3'd6;

    state_t           state, state_nx;
    logic [CNT_W-1:0] count, count_nx;
    logic [2:0]       op_r, op_nx;
    logic             fill_r, fill_nx;
    logic [1:0]       mode_r, mode_nx;
    logic [3:0]       par_r, par_nx;
    logic             clr_n_r, clr_n_nx;

    always_ff @(posedge clk) begin
        if (!CR) begin
            state   <= IDLE;
            count   <= '0;
            op_r    <= 3'd0;
            fill_r  <= 1'b0;
            mode_r  <= 2'b00;
            par_r   <= 4'd0;
            clr_n_r <= 1'b1;
        end else begin
            state   <= state_nx;
            count   <= count_nx;
            op_r    <= op_nx;
            fill_r  <= fill_nx;
            mode_r  <= mode_nx;
            par_r   <= par_nx;
            clr_n_r <= clr_n_nx;
        end
    end

    always_comb begin
        state_nx = state;
        count_nx = count;
        op_nx    = op_r;
        fill_nx  = fill_r;
        mode_nx  = mode_r;
        par_nx   = par_r;
        clr_n_nx = clr_n_r;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    op_nx    = cmd_op;
                    fill_nx  = cmd_fill;
                    state_nx = DONE;
                    case (cmd_op)
                        OP_LOAD: begin
                            state_nx = RUN;
                            count_nx = CNT_W'(1);
                            mode_nx  = 2'b11;
                            par_nx   = cmd_data;
                        end
                        OP_CLR: begin
                            state_nx = RUN;
                            count_nx = CNT_W'(1);
                            clr_n_nx = 1'b0;
                        end
                        OP_SHR, OP_ROR: begin
                            if (cmd_cnt != '0) begin
                                state_nx = RUN;
                                count_nx = cmd_cnt;
                                mode_nx  = 2'b01;
                            end
                        end
                        OP_SHL, OP_ROL: begin
                            if (cmd_cnt != '0) begin
                                state_nx = RUN;
                                count_nx = cmd_cnt;
                                mode_nx  = 2'b10;
                            end
                        end
                        default: state_nx = DONE;
                    endcase
                end
            end
            RUN: begin
                // Exiting at 1 means the count never wraps below zero.
                if (count == CNT_W'(1)) begin
                    state_nx = DONE;
                    count_nx = '0;
                    mode_nx  = 2'b00;
                    par_nx   = 4'd0;
                    clr_n_nx = 1'b1;
                end else begin
                    count_nx = count - CNT_W'(1);
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Rotates feed the register's own end bit straight back, so that path stays combinational.
    always_comb begin
        SR = 1'b0;
        SL = 1'b0;
        if (state == RUN) begin
            case (op_r)
                OP_SHR:  SR = fill_r;
                OP_ROR:  SR = q[0];
                OP_SHL:  SL = fill_r;
                OP_ROL:  SL = q[3];
                default: begin
                    SR = 1'b0;
                    SL = 1'b0;
                end
            endcase
        end
    end

    assign S1        = mode_r[1];
    assign S0        = mode_r[0];
    assign par       = par_r;
    assign reg_clr_n = clr_n_r;
    assign cmd_ready = (state == IDLE);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);

endmodule
